// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and constants for the instruction memory load arbiter.
package imem_load_arbiter_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 9;
   localparam int IMEM_DEPTH     = 2 ** DEF_ADDR_WIDTH;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/imem_load_arbiter.sv
// Shares the single instruction-memory port between CPU fetch and the program loader.
// Define IMEM_LOAD_CHECKSUM_EN to add the ld_sum running checksum output.
module imem_load_arbiter
   import imem_load_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_start,
   input  logic [ADDR_WIDTH-1:0] ld_base,
   input  logic [ADDR_WIDTH:0]   ld_count,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic                  ld_ready,
   output logic                  ld_busy,
   output logic                  ld_done,
   output logic                  ld_err,
`ifdef IMEM_LOAD_CHECKSUM_EN
   output logic [DATA_WIDTH-1:0] ld_sum,
`endif
   input  logic [ADDR_WIDTH-1:0] pc_addr,
   output logic                  cpu_stall,
   output logic                  fetch_valid,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_we
);

   // One extra bit beyond the count width so base+count can never wrap.
   localparam logic [ADDR_WIDTH+1:0] DEPTH = (ADDR_WIDTH+2)'(2 ** ADDR_WIDTH);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH:0]   rem;
   logic [ADDR_WIDTH+1:0] ld_end;
   logic                  req_bad;
   logic                  start_ok;
   logic                  accept;
   logic                  last_word;

   assign ld_end    = {2'b00, ld_base} + {1'b0, ld_count};
   assign req_bad   = (ld_count == '0) || (ld_end > DEPTH);
   assign start_ok  = (state == RUN) && ld_start && !req_bad;
   assign accept    = (state == LOAD) && ld_valid;
   assign last_word = accept && (rem == (ADDR_WIDTH+1)'(1));
   assign mem_data  = ld_data;

   always_comb begin
      state_nxt = state;
      mem_addr  = pc_addr;
      mem_we    = 1'b0;
      ld_ready  = 1'b0;
      cpu_stall = 1'b0;
      ld_busy   = 1'b0;
      unique case (state)
         RUN: begin
            if (start_ok) state_nxt = LOAD;
         end
         LOAD: begin
            cpu_stall = 1'b1;
            ld_busy   = 1'b1;
            ld_ready  = 1'b1;
            mem_addr  = ptr;
            mem_we    = ld_valid;
            if (last_word) state_nxt = FLUSH;
         end
         FLUSH: begin
            // Memory re-registers the held PC here so fetch resumes with valid data.
            cpu_stall = 1'b1;
            ld_busy   = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         ptr         <= '0;
         rem         <= '0;
         ld_done     <= 1'b0;
         ld_err      <= 1'b0;
         fetch_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         ld_done     <= last_word;
         fetch_valid <= (state == RUN) || (state == FLUSH);
         if ((state == RUN) && ld_start) ld_err <= req_bad;
         if (start_ok) begin
            ptr <= ld_base;
            rem <= ld_count;
         end else if (accept) begin
            ptr <= ptr + ADDR_WIDTH'(1);
            rem <= rem - (ADDR_WIDTH+1)'(1);
         end
      end
   end

`ifdef IMEM_LOAD_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst || start_ok) ld_sum <= '0;
      else if (accept)     ld_sum <= ld_sum + ld_data;
   end
`endif

endmodule
